// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode/funct/ALU encodings, control and ID/EX types, and the control decoder used by decode and execute
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  typedef struct packed {
    logic       issue;
    logic       jump;
    logic       use_rs;
    logic       use_rt;
    logic       dst_rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;
  typedef struct packed {
    logic [31:0] rega;
    logic [31:0] regb;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_op;
  } idex_t;
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.issue = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        c.use_rs = c.issue;
        c.use_rt = c.issue;
        c.dst_rd = c.issue;
        c.reg_write = c.issue;
        c.alu_op = !c.issue ? ALU_AND : fn == FN_ADD ? ALU_ADD : fn == FN_SUB ? ALU_SUB :
                   fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR : ALU_SLT;
      end
      OP_LW: begin
        c.issue = 1'b1;
        c.use_rs = 1'b1;
        c.reg_write = 1'b1;
        c.mem_read = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op = ALU_ADD;
      end
      OP_SW: begin
        c.issue = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.mem_write = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        c.issue = 1'b1;
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.issue = 1'b1;
        c.use_rs = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op = ALU_ADD;
      end
      OP_J: c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 32x32 2R1W register file, r0 reads 0, write-through bypass; ports clk, we/wa/wd write, ra/rb -> rd_a/rd_b
module decode_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b
);
  logic [31:0] rf_q [32];
  always_ff @(posedge clk) if (we && wa != 5'd0) rf_q[wa] <= wd;
  assign rd_a = ra == 5'd0 ? '0 : (we && wa == ra) ? wd : rf_q[ra];
  assign rd_b = rb == 5'd0 ? '0 : (we && wa == rb) ? wd : rf_q[rb];
endmodule

// File: rtl/decode.sv
// decode: ID stage (IF/ID reg, decoder, load-use hazard, regfile, ID/EX reg); in clk, reset(active-low), IF instr/PC+4, EX redirect, WB write; out AnyStall, Jump_ID/JumpTgt_ID, ID/EX fields
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FetchData_IF,
  input  logic [31:0] NPc_IF,
  input  logic        BranchTaken_EX,
  input  logic        RegWrite_WB,
  input  logic [4:0]  WriteReg_WB,
  input  logic [31:0] Result_WB,
  output logic        AnyStall,
  output logic        Jump_ID,
  output logic [25:0] JumpTgt_ID,
  output logic [31:0] RegA_EX,
  output logic [31:0] RegB_EX,
  output logic [31:0] Imm_EX,
  output logic [31:0] NPc_EX,
  output logic [4:0]  Rs_EX,
  output logic [4:0]  Rt_EX,
  output logic [4:0]  WriteReg_EX,
  output logic        RegWrite_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        Branch_EX,
  output logic        AluSrc_EX,
  output logic [2:0]  AluOp_EX
);
  logic [31:0] instr_q, instr_d, npc_q, npc_d, rd_a, rd_b;
  logic        valid_q, valid_d;
  logic [4:0]  rs, rt, rd;
  ctrl_t       ctrl;
  idex_t       ex_q, ex_d, dec;
  decode_regfile regfile (
    .clk  (clk),
    .we   (RegWrite_WB),
    .wa   (WriteReg_WB),
    .wd   (Result_WB),
    .ra   (rs),
    .rb   (rt),
    .rd_a (rd_a),
    .rd_b (rd_b)
  );
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign rd = instr_q[15:11];
  assign ctrl = valid_q ? decode_ctrl(instr_q[31:26], instr_q[5:0]) : '0;
  assign AnyStall = ex_q.mem_read && ex_q.wr != 5'd0 &&
                    ((ctrl.use_rs && rs == ex_q.wr) || (ctrl.use_rt && rt == ex_q.wr));
  assign Jump_ID = ctrl.jump && !BranchTaken_EX;
  assign JumpTgt_ID = instr_q[25:0];
  always_comb begin
    instr_d = BranchTaken_EX ? '0 : AnyStall ? instr_q : FetchData_IF;
    npc_d = BranchTaken_EX ? '0 : AnyStall ? npc_q : NPc_IF;
    valid_d = !BranchTaken_EX && (valid_q || !AnyStall);
    dec = '{rega: rd_a, regb: rd_b, imm: {{16{instr_q[15]}}, instr_q[15:0]}, npc: npc_q,
            rs: rs, rt: rt, wr: ctrl.reg_write ? (ctrl.dst_rd ? rd : rt) : 5'd0,
            reg_write: ctrl.reg_write, mem_read: ctrl.mem_read, mem_write: ctrl.mem_write,
            branch: ctrl.branch, alu_src: ctrl.alu_src, alu_op: ctrl.alu_op};
    ex_d = (ctrl.issue && !AnyStall && !BranchTaken_EX) ? dec : '0;
  end
  always_ff @(posedge clk) begin
    instr_q <= reset ? instr_d : '0;
    npc_q <= reset ? npc_d : '0;
    valid_q <= reset ? valid_d : 1'b0;
    ex_q <= reset ? ex_d : '0;
  end
  assign {RegA_EX, RegB_EX, Imm_EX, NPc_EX, Rs_EX, Rt_EX, WriteReg_EX,
          RegWrite_EX, MemRead_EX, MemWrite_EX, Branch_EX, AluSrc_EX, AluOp_EX} = ex_q;
endmodule

// File: tb/tb_decode.sv
// tb_decode: randomized scoreboard bench for decode against a table-driven instruction-level model
module tb_decode;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] FetchData_IF = '0, NPc_IF = '0, Result_WB = '0;
  logic        BranchTaken_EX = 1'b0, RegWrite_WB = 1'b0;
  logic [4:0]  WriteReg_WB = '0;
  logic        AnyStall, Jump_ID;
  logic [25:0] JumpTgt_ID;
  logic [31:0] RegA_EX, RegB_EX, Imm_EX, NPc_EX;
  logic [4:0]  Rs_EX, Rt_EX, WriteReg_EX;
  logic        RegWrite_EX, MemRead_EX, MemWrite_EX, Branch_EX, AluSrc_EX;
  logic [2:0]  AluOp_EX;
  always #5 clk = ~clk;
  decode dut (
    .clk(clk), .reset(reset), .FetchData_IF(FetchData_IF), .NPc_IF(NPc_IF),
    .BranchTaken_EX(BranchTaken_EX), .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
    .Result_WB(Result_WB), .AnyStall(AnyStall), .Jump_ID(Jump_ID), .JumpTgt_ID(JumpTgt_ID),
    .RegA_EX(RegA_EX), .RegB_EX(RegB_EX), .Imm_EX(Imm_EX), .NPc_EX(NPc_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .WriteReg_EX(WriteReg_EX), .RegWrite_EX(RegWrite_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX),
    .AluSrc_EX(AluSrc_EX), .AluOp_EX(AluOp_EX)
  );
  typedef struct {
    logic [31:0] rega, regb, imm, npc;
    logic [4:0]  rs, rt, wr;
    logic        rw, mr, mw, br, as;
    logic [2:0]  aop;
  } ex_t;
  typedef struct {
    ex_t         ex;
    logic        stall, jump;
    logic [25:0] tgt;
  } exp_t;
  localparam int K_NONE = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_OR = 4, K_SLT = 5,
                 K_LW = 6, K_SW = 7, K_BEQ = 8, K_ADDI = 9, K_J = 10;
  bit         t_rs  [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit         t_rt  [11] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  bit         t_wr  [11] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
  logic [2:0] t_alu [11] = '{3'd0, 3'd2, 3'd6, 3'd0, 3'd1, 3'd7, 3'd2, 3'd2, 3'd6, 3'd2, 3'd0};
  exp_t        q[$];
  int          vectors = 0, errors = 0;
  logic [31:0] m_rf [32];
  logic [31:0] m_if = '0, m_npc = '0;
  bit          m_valid = 0;
  ex_t         m_ex = '{default: '0};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int kind_of(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00)
      return fn == 6'h20 ? K_ADD : fn == 6'h22 ? K_SUB : fn == 6'h24 ? K_AND :
             fn == 6'h25 ? K_OR : fn == 6'h2a ? K_SLT : K_NONE;
    return op == 6'h23 ? K_LW : op == 6'h2b ? K_SW : op == 6'h04 ? K_BEQ :
           op == 6'h08 ? K_ADDI : op == 6'h02 ? K_J : K_NONE;
  endfunction
  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] d, s, t);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] t, s, input logic [15:0] im);
    return {op, s, t, im};
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [4:0] s, t, d;
    logic [15:0] im;
    int k;
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    k = $urandom_range(0, 12);
    case (k)
      0: return r_ins(6'h20, d, s, t);
      1: return r_ins(6'h22, d, s, t);
      2: return r_ins(6'h24, d, s, t);
      3: return r_ins(6'h25, d, s, t);
      4: return r_ins(6'h2a, d, s, t);
      5, 12: return i_ins(6'h23, t, s, im);
      6: return i_ins(6'h2b, t, s, im);
      7: return i_ins(6'h04, t, s, im);
      8: return i_ins(6'h08, t, s, im);
      9: return {6'h02, 26'($urandom)};
      10: return {6'h00, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [31:0] rf_read(input logic [4:0] r, input bit rw, input logic [4:0] wr, input logic [31:0] res);
    return r == 0 ? 32'h0 : (rw && wr == r) ? res : m_rf[r];
  endfunction
  task automatic step(input bit rst_n, input logic [31:0] f, input bit bt, input bit rw,
                      input logic [4:0] wr, input logic [31:0] res);
    exp_t e;
    ex_t n;
    int k;
    logic [4:0] rs, rt, rd;
    logic [31:0] npc;
    @(posedge clk);
    #1;
    npc = $urandom;
    reset = rst_n;
    FetchData_IF = f;
    NPc_IF = npc;
    BranchTaken_EX = bt;
    RegWrite_WB = rw;
    WriteReg_WB = wr;
    Result_WB = res;
    k = m_valid ? kind_of(m_if) : K_NONE;
    rs = m_if[25:21];
    rt = m_if[20:16];
    rd = m_if[15:11];
    e.ex = m_ex;
    e.stall = m_ex.mr && m_ex.wr != 0 && ((t_rs[k] && rs == m_ex.wr) || (t_rt[k] && rt == m_ex.wr));
    e.jump = k == K_J && !bt;
    e.tgt = m_if[25:0];
    q.push_back(e);
    n = '{default: '0};
    if (!(e.stall || bt || k == K_NONE || k == K_J)) begin
      n.rega = rf_read(rs, rw, wr, res);
      n.regb = rf_read(rt, rw, wr, res);
      n.imm = 32'($signed(m_if[15:0]));
      n.npc = m_npc;
      n.rs = rs;
      n.rt = rt;
      n.rw = t_wr[k];
      n.wr = !t_wr[k] ? 5'd0 : (k <= K_SLT) ? rd : rt;
      n.mr = k == K_LW;
      n.mw = k == K_SW;
      n.br = k == K_BEQ;
      n.as = k == K_LW || k == K_SW || k == K_ADDI;
      n.aop = t_alu[k];
    end
    if (!rst_n) begin
      m_if = '0;
      m_npc = '0;
      m_valid = 0;
      m_ex = '{default: '0};
    end else begin
      m_ex = n;
      if (bt) begin
        m_if = '0;
        m_npc = '0;
        m_valid = 0;
      end else if (!e.stall) begin
        m_if = f;
        m_npc = npc;
        m_valid = 1;
      end
    end
    if (rw && wr != 0) m_rf[wr] = res;
  endtask
  task automatic idle();
    step(1, 32'h0, 0, 0, 5'd0, 32'h0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("AnyStall", AnyStall, e.stall);
        chk("Jump_ID", Jump_ID, e.jump);
        chk("JumpTgt_ID", JumpTgt_ID, e.tgt);
        chk("RegA_EX", RegA_EX, e.ex.rega);
        chk("RegB_EX", RegB_EX, e.ex.regb);
        chk("Imm_EX", Imm_EX, e.ex.imm);
        chk("NPc_EX", NPc_EX, e.ex.npc);
        chk("Rs_EX", Rs_EX, e.ex.rs);
        chk("Rt_EX", Rt_EX, e.ex.rt);
        chk("WriteReg_EX", WriteReg_EX, e.ex.wr);
        chk("RegWrite_EX", RegWrite_EX, e.ex.rw);
        chk("MemRead_EX", MemRead_EX, e.ex.mr);
        chk("MemWrite_EX", MemWrite_EX, e.ex.mw);
        chk("Branch_EX", Branch_EX, e.ex.br);
        chk("AluSrc_EX", AluSrc_EX, e.ex.as);
        chk("AluOp_EX", AluOp_EX, e.ex.aop);
      end
    end
  end
  initial begin
    bit rst_n, rw;
    m_rf[0] = '0;
    repeat (2) @(posedge clk);
    step(0, 32'h0, 0, 0, 5'd0, 32'h0);
    step(0, 32'h0, 0, 0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("reset AnyStall", AnyStall, 0);
    chk("reset Jump_ID", Jump_ID, 0);
    chk("reset RegWrite_EX", RegWrite_EX, 0);
    chk("reset RegA_EX", RegA_EX, 0);
    for (int i = 1; i < 32; i++) step(1, 32'h0, 0, 1, 5'(i), $urandom);
    step(1, r_ins(6'h20, 5'd3, 5'd5, 5'd5), 0, 0, 5'd0, 32'h0);
    step(1, 32'h0, 0, 1, 5'd5, 32'h1234);
    idle();
    @(negedge clk);
    chk("bypass RegA_EX", RegA_EX, 32'h1234);
    chk("bypass RegB_EX", RegB_EX, 32'h1234);
    chk("bypass AluOp_EX", AluOp_EX, 3'b010);
    chk("bypass WriteReg_EX", WriteReg_EX, 5'd3);
    step(1, i_ins(6'h23, 5'd2, 5'd1, 16'h0), 0, 0, 5'd0, 32'h0);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 0, 0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("loaduse AnyStall", AnyStall, 1);
    idle();
    @(negedge clk);
    chk("loaduse release AnyStall", AnyStall, 0);
    chk("loaduse bubble RegWrite_EX", RegWrite_EX, 0);
    idle();
    @(negedge clk);
    chk("loaduse issue WriteReg_EX", WriteReg_EX, 5'd4);
    chk("loaduse issue RegWrite_EX", RegWrite_EX, 1);
    step(1, 32'h0800_0010, 0, 0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("j Jump_ID", Jump_ID, 1);
    chk("j JumpTgt_ID", JumpTgt_ID, 26'h10);
    idle();
    @(negedge clk);
    chk("j RegWrite_EX", RegWrite_EX, 0);
    step(1, i_ins(6'h23, 5'd2, 5'd1, 16'h0), 0, 0, 5'd0, 32'h0);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 0, 0, 5'd0, 32'h0);
    step(1, 32'h0, 1, 0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("flush AnyStall", AnyStall, 0);
    chk("flush MemRead_EX", MemRead_EX, 0);
    idle();
    @(negedge clk);
    chk("flush discards add", RegWrite_EX, 0);
    step(1, i_ins(6'h23, 5'd2, 5'd1, 16'h0), 0, 0, 5'd0, 32'h0);
    step(1, r_ins(6'h20, 5'd4, 5'd2, 5'd3), 0, 0, 5'd0, 32'h0);
    step(0, 32'h0, 0, 0, 5'd0, 32'h0);
    idle();
    @(negedge clk);
    chk("reset mid-stall AnyStall", AnyStall, 0);
    chk("reset mid-stall MemRead_EX", MemRead_EX, 0);
    idle();
    @(negedge clk);
    chk("reset discards add", RegWrite_EX, 0);
    step(1, i_ins(6'h08, 5'd0, 5'd0, 16'd7), 0, 0, 5'd0, 32'h0);
    step(1, r_ins(6'h20, 5'd6, 5'd0, 5'd0), 0, 0, 5'd0, 32'h0);
    step(1, 32'h0, 0, 1, 5'd0, 32'd7);
    idle();
    @(negedge clk);
    chk("r0 RegA_EX", RegA_EX, 0);
    chk("r0 RegB_EX", RegB_EX, 0);
    step(1, 32'hFC21_1820, 0, 0, 5'd0, 32'h0);
    idle();
    idle();
    @(negedge clk);
    chk("bad opcode RegWrite_EX", RegWrite_EX, 0);
    chk("bad opcode AluOp_EX", AluOp_EX, 0);
    for (int i = 0; i < 2500; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      rw = rst_n && $urandom_range(0, 1) == 1;
      step(rst_n, rnd_instr(), $urandom_range(0, 9) == 0, rw,
           5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)), $urandom);
    end
    idle();
    repeat (2) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
